// File: rtl/blinker.sv
// Eight-LED pattern sequencer: prescaled step tick drives either a one-hot
// rotate-left chase (sw0=1) or a one-hot ping-pong sweep (sw0=0).
module blinker #(
    parameter logic [31:0] TICK_DIV = 32'd2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw0,
    output logic [7:0] led
);

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    logic        s1, s2;
    logic        mode;
    logic [31:0] cnt;
    logic        tick;
    logic        onehot;
    dir_t        dir, dir_nxt;
    logic [7:0]  led_nxt;

    assign mode   = s2;
    assign tick   = (cnt == TICK_DIV - 32'd1);
    assign onehot = (led != 8'h00) && ((led & (led - 8'd1)) == 8'h00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            led <= 8'h01;
            dir <= UP;
        end else begin
            s1  <= sw0;
            s2  <= s1;
            cnt <= tick ? 32'd0 : cnt + 32'd1;
            led <= led_nxt;
            dir <= dir_nxt;
        end
    end

    // Mode switches keep the current position; the new rule applies from it.
    always_comb begin
        led_nxt = led;
        dir_nxt = dir;
        if (tick) begin
            if (!onehot) begin
                led_nxt = 8'h01;
                dir_nxt = UP;
            end else if (mode) begin
                led_nxt = {led[6:0], led[7]};
                dir_nxt = UP;
            end else if (dir == UP) begin
                if (led == 8'h80) begin
                    led_nxt = 8'h40;
                    dir_nxt = DOWN;
                end else begin
                    led_nxt = {led[6:0], 1'b0};
                end
            end else begin
                if (led == 8'h01) begin
                    led_nxt = 8'h02;
                    dir_nxt = UP;
                end else begin
                    led_nxt = {1'b0, led[7:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_blinker.sv
// Directed bench for blinker: TICK_DIV=4 instance for pattern/timing/mode
// behaviour and a TICK_DIV=1 instance for the step-every-cycle edge case.
module tb_blinker;

    logic       clk;
    logic       rst4, sw04, rst1, sw01;
    logic [7:0] led4, led1;
    int         checks, errors;

    blinker #(.TICK_DIV(32'd4)) dut4 (.clk(clk), .rst(rst4), .sw0(sw04), .led(led4));
    blinker #(.TICK_DIV(32'd1)) dut1 (.clk(clk), .rst(rst1), .sw0(sw01), .led(led1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rot_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] pp_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One TICK_DIV=4 step: three edges holding, then the step edge.
    task automatic step4(input string tag, input logic [7:0] prev, input logic [7:0] exp);
        cyc(3);
        chk({tag, "_hold"}, led4, prev);
        cyc(1);
        chk(tag, led4, exp);
    endtask

    initial begin
        logic [7:0] prev;
        checks = 0;
        errors = 0;
        rst4 = 1'b0; sw04 = 1'b1;
        rst1 = 1'b0; sw01 = 1'b1;

        // Reset held for 5 edges
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("rst_hold4", led4, 8'h01);
            chk("rst_hold1", led1, 8'h01);
        end

        // Rotate: first step on the 4th edge after release, wraps after 8
        rst4 = 1'b1;
        prev = 8'h01;
        for (int k = 0; k < 8; k++) begin
            step4("rot", prev, rot_exp[k]);
            prev = rot_exp[k];
        end
        for (int k = 0; k < 7; k++) begin
            step4("rot2", prev, rot_exp[k]);
            prev = rot_exp[k];
        end

        // At 80 in rotate, switch to ping-pong well before the tick
        sw04 = 1'b0;
        step4("sw_end", 8'h80, 8'h40);
        step4("sw_dn1", 8'h40, 8'h20);
        step4("sw_dn2", 8'h20, 8'h10);
        // Moving down at 10, back to rotate: rotate left
        sw04 = 1'b1;
        step4("sw_rot1", 8'h10, 8'h20);
        step4("sw_rot2", 8'h20, 8'h40);

        // sw0 changes 1 cycle before a tick: that tick still rotates
        cyc(3);
        chk("lat_hold", led4, 8'h40);
        sw04 = 1'b0;
        cyc(1);
        chk("lat_old", led4, 8'h80);
        step4("lat_new", 8'h80, 8'h40);
        step4("lat_new2", 8'h40, 8'h20);

        // Reset mid-sequence
        cyc(1);
        rst4 = 1'b0;
        cyc(1);
        chk("rst_mid", led4, 8'h01);
        cyc(1);
        chk("rst_mid2", led4, 8'h01);

        // Ping-pong from reset, full period plus one
        rst4 = 1'b1;
        prev = 8'h01;
        for (int k = 0; k < 15; k++) begin
            step4("pp", prev, pp_exp[k]);
            prev = pp_exp[k];
        end

        // TICK_DIV=1: step every edge, first edge after release
        rst1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            chk("div1", led1, rot_exp[k]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
